mem_accum_ctrl: RTL and testbench

- Sequencer and accumulator stage that sits directly upstream of the 16x8 synchronous memory, driving its rw, addr and data_in inputs and consuming its data_out.
- On a start pulse it reads COUNT consecutive locations from a base address, wrapping modulo 16, and sums them into a wide accumulator.
- Optionally writes the saturated 8-bit result back to a chosen memory location, then pulses done.

---
 rtl/mem_accum_ctrl.sv | 113 +++++++++++
 tb/tb_mem_accum_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_accum_ctrl.sv
`default_nettype none
// ============================================================================
// mem_accum_ctrl : sequences COUNT reads from a synchronous memory, sums them
//                  and optionally writes the saturated sum back.
// Revision: 1.0  initial release
// ============================================================================
module mem_accum_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy,
   output logic              done,
   output logic [ACC_W-1:0]  sum
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_wb_addr;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W:0]   r_count;
   logic              r_wb_en;
   logic              r_rd_vld;
   logic [ACC_W-1:0]  r_sum;

   logic [ADDR_W:0]   w_last_idx;
   logic [DATA_W-1:0] w_sat;

   assign w_last_idx = r_count - {{ADDR_W{1'b0}}, 1'b1};
   // Any bit above the data width set means the sum no longer fits a word.
   assign w_sat      = (|r_sum[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : r_sum[DATA_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_base    <= '0;
         r_wb_addr <= '0;
         r_idx     <= '0;
         r_count   <= '0;
         r_wb_en   <= 1'b0;
         r_rd_vld  <= 1'b0;
         r_sum     <= '0;
      end else begin
         // Memory data lags the read address by one cycle.
         r_rd_vld <= (r_state == S_READ);
         if (r_rd_vld) begin
            r_sum <= r_sum + {{(ACC_W-DATA_W){1'b0}}, mem_data_out};
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_base    <= base_addr;
                  r_count   <= count;
                  r_wb_en   <= wb_en;
                  r_wb_addr <= wb_addr;
                  r_idx     <= '0;
                  r_sum     <= '0;
                  if (count == '0) begin
                     r_state <= wb_en ? S_WRITE : S_DONE;
                  end else begin
                     r_state <= S_READ;
                  end
               end
            end
            S_READ: begin
               r_idx <= r_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
               if ({1'b0, r_idx} == w_last_idx) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: r_state <= r_wb_en ? S_WRITE : S_DONE;
            S_WRITE: r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      mem_addr = '0;
      if (r_state == S_READ) begin
         mem_addr = r_base + r_idx;
      end else if (r_state == S_WRITE) begin
         mem_addr = r_wb_addr;
      end
   end

   // The memory writes on every edge with rw low, so only WRITE may drop it.
   assign mem_rw      = (r_state != S_WRITE);
   assign mem_data_in = (r_state == S_WRITE) ? w_sat : '0;
   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign sum         = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_mem_accum_ctrl.sv
`default_nettype none
// Bench for mem_accum_ctrl: 16x8 memory model, transaction-level reference
// model with a per-cycle comparator, directed cases plus random transactions.
module tb_mem_accum_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  base_addr;
   logic [4:0]  count;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic        mem_rw;
   logic [3:0]  mem_addr;
   logic [7:0]  mem_data_in;
   logic [7:0]  mem_data_out;
   logic        busy;
   logic        done;
   logic [11:0] sum;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] mem [16];
   logic [7:0] img [16];
   logic       ld_all;
   int         wr_cnt = 0;
   logic [3:0] last_wa;
   logic [7:0] last_wd;

   mem_accum_ctrl #(.ADDR_W(4), .DATA_W(8), .ACC_W(12)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .base_addr    (base_addr),
      .count        (count),
      .wb_en        (wb_en),
      .wb_addr      (wb_addr),
      .mem_rw       (mem_rw),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out),
      .busy         (busy),
      .done         (done),
      .sum          (sum)
   );

   always #5 clk = ~clk;

   // 16x8 synchronous memory; ld_all lets the bench preload an image.
   always @(posedge clk) begin
      if (ld_all) begin
         mem <= img;
      end else if (!mem_rw) begin
         mem[mem_addr] <= mem_data_in;
         wr_cnt        <= wr_cnt + 1;
         last_wa       <= mem_addr;
         last_wd       <= mem_data_in;
      end
      mem_data_out <= mem[mem_addr];
   end

   task automatic chk(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   // Reference model: one transaction described by its cycle index since
   // the accepting edge, its read list prefix sums and its done cycle.
   bit         m_active;
   bit         m_was_idle;
   bit         m_wb;
   int         m_k;
   int         m_n;
   int         m_done_cyc;
   int         m_total;
   int         m_hold;
   int         m_pref [17];
   logic [3:0] m_base;
   logic [3:0] m_wba;
   logic [3:0] m_a;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_hold   = 0;
         m_k      = 0;
      end else begin
         m_was_idle = !m_active;
         if (m_active) begin
            m_k++;
            if (m_k > m_done_cyc) begin
               m_active = 1'b0;
               m_hold   = m_total;
            end
         end
         if (m_was_idle && start) begin
            m_base    = base_addr;
            m_n       = int'(count);
            m_wb      = wb_en;
            m_wba     = wb_addr;
            m_pref[0] = 0;
            for (int i = 0; i < 16; i++) begin
               m_a         = m_base + 4'(i);
               m_pref[i+1] = m_pref[i] + ((i < m_n) ? int'(mem[m_a]) : 0);
            end
            m_total    = m_pref[m_n];
            m_done_cyc = (m_n == 0) ? 1 + int'(m_wb) : m_n + 2 + int'(m_wb);
            m_k        = 1;
            m_active   = 1'b1;
         end
      end
   end

   int         e_nsum;
   logic [3:0] e_addr;
   bit         e_rw;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_rw",   int'(mem_rw),      1);
         chk("rst_busy", int'(busy),        0);
         chk("rst_done", int'(done),        0);
         chk("rst_sum",  int'(sum),         0);
         chk("rst_addr", int'(mem_addr),    0);
         chk("rst_din",  int'(mem_data_in), 0);
      end else if (m_active) begin
         e_rw   = !(m_wb && (m_k == m_done_cyc - 1));
         e_nsum = (m_k < 2) ? 0 : ((m_k - 2 < m_n) ? m_k - 2 : m_n);
         chk("busy", int'(busy),   1);
         chk("done", int'(done),   int'(m_k == m_done_cyc));
         chk("rw",   int'(mem_rw), int'(e_rw));
         chk("sum",  int'(sum),    m_pref[e_nsum]);
         if (m_k <= m_n) begin
            e_addr = m_base + 4'(m_k - 1);
            chk("rd_addr", int'(mem_addr), int'(e_addr));
         end
         if (!e_rw) begin
            chk("wr_addr", int'(mem_addr),    int'(m_wba));
            chk("wr_data", int'(mem_data_in), (m_total > 255) ? 255 : m_total);
         end
      end else begin
         chk("idle_busy", int'(busy),   0);
         chk("idle_done", int'(done),   0);
         chk("idle_rw",   int'(mem_rw), 1);
         chk("idle_sum",  int'(sum),    m_hold);
      end
   end

   task automatic load();
      @(posedge clk); #1 ld_all = 1'b1;
      @(posedge clk); #1 ld_all = 1'b0;
   endtask

   task automatic run(input logic [3:0] b, input logic [4:0] c, input bit w,
                      input logic [3:0] wa, input int exp_lat, input string nm);
      int lat;
      @(posedge clk); #1;
      base_addr = b; count = c; wb_en = w; wb_addr = wa; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
      end
      chk({nm, "_lat"}, lat, exp_lat);
      @(posedge clk); #1;
   endtask

   int w0;
   int diffs;
   int s;
   int c;
   bit w;
   logic [3:0] b;
   logic [3:0] wa;
   logic [3:0] ra;

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0;
      wb_en = 1'b0; wb_addr = '0; ld_all = 1'b0;
      for (int i = 0; i < 16; i++) img[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: ten words 0x0A..0x64, no write-back
      for (int i = 0; i < 10; i++) img[i] = 8'(10 * (i + 1));
      load();
      w0 = wr_cnt;
      run(4'd0, 5'd10, 1'b0, 4'd0, 12, "t1");
      chk("t1_sum", int'(sum), 'h226);
      chk("t1_nowr", wr_cnt - w0, 0);

      // 2: same data, saturated write-back to 15
      w0 = wr_cnt;
      run(4'd0, 5'd10, 1'b1, 4'd15, 13, "t2");
      chk("t2_sum", int'(sum), 'h226);
      chk("t2_wrcnt", wr_cnt - w0, 1);
      chk("t2_wa", int'(last_wa), 15);
      chk("t2_wd", int'(last_wd), 'hFF);
      chk("t2_mem15", int'(mem[15]), 'hFF);

      // 3: wrap-around read 14,15,0,1
      for (int i = 0; i < 16; i++) img[i] = 8'h00;
      img[14] = 8'd1; img[15] = 8'd2; img[0] = 8'd3; img[1] = 8'd4;
      load();
      run(4'd14, 5'd4, 1'b1, 4'd2, 7, "t3");
      chk("t3_sum", int'(sum), 'h00A);
      chk("t3_mem2", int'(mem[2]), 'h0A);

      // 4: zero count with write-back
      img[5] = 8'h33;
      load();
      run(4'd9, 5'd0, 1'b1, 4'd5, 2, "t4");
      chk("t4_sum", int'(sum), 0);
      chk("t4_mem5", int'(mem[5]), 0);

      // 5: start while busy, then reset mid-READ
      for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
      load();
      w0 = wr_cnt;
      @(posedge clk); #1;
      base_addr = 4'd2; count = 5'd12; wb_en = 1'b1; wb_addr = 4'd3; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      base_addr = 4'd7; count = 5'd3; wb_en = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("t5_rw", int'(mem_rw), 1);
      chk("t5_busy", int'(busy), 0);
      chk("t5_sum", int'(sum), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      diffs = 0;
      for (int i = 0; i < 16; i++) if (mem[i] !== img[i]) diffs++;
      chk("t5_memdiff", diffs, 0);
      chk("t5_nowr", wr_cnt - w0, 0);
      run(4'd6, 5'd5, 1'b0, 4'd0, 7, "t5b");

      // 6: full sweep of 0xFF words
      for (int i = 0; i < 16; i++) img[i] = 8'hFF;
      load();
      run(4'd3, 5'd16, 1'b0, 4'd0, 18, "t6");
      chk("t6_sum", int'(sum), 'hFF0);

      // random transactions
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
         load();
         b  = 4'($urandom_range(0, 15));
         c  = $urandom_range(0, 16);
         w  = 1'($urandom_range(0, 1));
         wa = 4'($urandom_range(0, 15));
         s  = 0;
         for (int i = 0; i < c; i++) begin
            ra = b + 4'(i);
            s += int'(img[ra]);
         end
         run(b, 5'(c), w, wa, (c == 0) ? 1 + int'(w) : c + 2 + int'(w), "rnd");
         chk("rnd_sum", int'(sum), s);
         if (w) chk("rnd_wbmem", int'(mem[wa]), (s > 255) ? 255 : s);
      end

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
